// File: rtl/alu_pkg.sv
// alu_pkg: defaults and result-entry layout shared by the ALU result
// buffer and the ALU_VECTORIAL benches.
//   WIDTH_DEF     default lane width in bits
//   N_ALU_DEF     default number of ALU lanes
//   alu_result_t  one captured ALU result (data, carry, gt, eq, lt)
//   entry_width() width of a flattened entry for any WIDTH/n_alu pair
package alu_pkg;

    localparam int unsigned WIDTH_DEF = 4;
    localparam int unsigned N_ALU_DEF = 4;

    typedef struct packed {
        logic [WIDTH_DEF*N_ALU_DEF-1:0] data;
        logic [N_ALU_DEF-1:0]           carry;
        logic [N_ALU_DEF-1:0]           gt;
        logic [N_ALU_DEF-1:0]           eq;
        logic [N_ALU_DEF-1:0]           lt;
    } alu_result_t;

    // Field order matches alu_result_t: data, then four per-lane flag vectors.
    function automatic int unsigned entry_width(input int unsigned width,
                                                input int unsigned lanes);
        return width * lanes + 4 * lanes;
    endfunction

endpackage

// File: rtl/alu_latency_pipe.sv
// alu_latency_pipe: shift register that delays the ALU issue strobe so that
// its output lines up with the cycle in which the ALU results are valid.
//   clk    clock
//   arst   asynchronous active-high reset, clears all stages
//   flush  synchronous clear of all stages
//   din    issue strobe (enable)
//   dout   delayed strobe (cap_valid), STAGES cycles after din is sampled
module alu_latency_pipe #(
    parameter int unsigned STAGES = 1
) (
    input  logic clk,
    input  logic arst,
    input  logic flush,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] pipe;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            pipe <= '0;
        end else if (flush) begin
            pipe <= '0;
        end else begin
            pipe[0] <= din;
            for (int unsigned i = 1; i < STAGES; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign dout = pipe[STAGES-1];

endmodule

// File: rtl/alu_result_buffer.sv
// alu_result_buffer: captures ALU_VECTORIAL results ALU_LATENCY cycles after
// each issue and queues them in a first-word-fall-through FIFO.
//   clk, arst                         clock, async active-high reset
//   enable                            ALU issue strobe
//   data_out, carry_out, a_greater,
//   a_equal, a_less                   ALU result vector and per-lane flags
//   flush                             sync clear of FIFO and latency pipe
//   clr_ovf                           sync clear of sticky overflow
//   res_valid, res_ready              head handshake
//   res_data, res_carry, res_gt,
//   res_eq, res_lt                    head entry fields
//   count, full, empty                occupancy
//   overflow                          sticky: a captured result was dropped
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH       = WIDTH_DEF,
    parameter int unsigned n_alu       = N_ALU_DEF,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned ALU_LATENCY = 1
) (
    input  logic                       clk,
    input  logic                       arst,
    input  logic                       enable,
    input  logic [WIDTH*n_alu-1:0]     data_out,
    input  logic [n_alu-1:0]           carry_out,
    input  logic [n_alu-1:0]           a_greater,
    input  logic [n_alu-1:0]           a_equal,
    input  logic [n_alu-1:0]           a_less,
    input  logic                       flush,
    input  logic                       clr_ovf,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [WIDTH*n_alu-1:0]     res_data,
    output logic [n_alu-1:0]           res_carry,
    output logic [n_alu-1:0]           res_gt,
    output logic [n_alu-1:0]           res_eq,
    output logic [n_alu-1:0]           res_lt,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned EW    = entry_width(WIDTH, n_alu);

    logic             cap_valid;
    logic             push;
    logic             pop;
    logic             drop;
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [EW-1:0]    wr_entry;
    logic [EW-1:0]    mem [DEPTH];

    alu_latency_pipe #(
        .STAGES (ALU_LATENCY)
    ) u_latency_pipe (
        .clk   (clk),
        .arst  (arst),
        .flush (flush),
        .din   (enable),
        .dout  (cap_valid)
    );

    assign wr_entry = {data_out, carry_out, a_greater, a_equal, a_less};

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign res_valid = !empty;

    // At full a push still succeeds if the head leaves in the same cycle; a
    // flush discards whatever is being captured and does not count as a drop.
    assign pop  = res_valid && res_ready;
    assign push = cap_valid && !flush && (!full || pop);
    assign drop = cap_valid && !flush && full && !pop;

    assign {res_data, res_carry, res_gt, res_eq, res_lt} = mem[rptr];

    // Storage is not reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // A new drop wins over clr_ovf in the same cycle.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_result_buffer.sv
// tb_alu_result_buffer: directed self-checking bench for alu_result_buffer
// (WIDTH=4, n_alu=4, DEPTH=8, ALU_LATENCY=1). ALU outputs are presented one
// cycle after the enable that issued them.
module tb_alu_result_buffer;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] data_out = '0;
    logic [3:0]  carry_out = '0;
    logic [3:0]  a_greater = '0;
    logic [3:0]  a_equal = '0;
    logic [3:0]  a_less = '0;
    logic        flush = 1'b0;
    logic        clr_ovf = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_data;
    logic [3:0]  res_carry;
    logic [3:0]  res_gt;
    logic [3:0]  res_eq;
    logic [3:0]  res_lt;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic        overflow;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    alu_result_t pend;
    alu_result_t junk;

    always #5 clk = ~clk;

    alu_result_buffer #(
        .WIDTH       (4),
        .n_alu       (4),
        .DEPTH       (8),
        .ALU_LATENCY (1)
    ) dut (
        .clk       (clk),
        .arst      (arst),
        .enable    (enable),
        .data_out  (data_out),
        .carry_out (carry_out),
        .a_greater (a_greater),
        .a_equal   (a_equal),
        .a_less    (a_less),
        .flush     (flush),
        .clr_ovf   (clr_ovf),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_carry (res_carry),
        .res_gt    (res_gt),
        .res_eq    (res_eq),
        .res_lt    (res_lt),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Distinct, easily recognisable entry for id k.
    function automatic alu_result_t mk(input logic [7:0] k);
        alu_result_t r;
        r.data  = {k, ~k};
        r.carry = k[3:0];
        r.gt    = k[7:4];
        r.eq    = ~k[7:4];
        r.lt    = k[3:0] ^ 4'hA;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock: present the result of the previous issue, issue a new one.
    task automatic cyc(input logic en, input alu_result_t r);
        data_out  = pend.data;
        carry_out = pend.carry;
        a_greater = pend.gt;
        a_equal   = pend.eq;
        a_less    = pend.lt;
        enable    = en;
        pend      = en ? r : junk;
        tick();
    endtask

    task automatic chk_head(input string tag, input alu_result_t r);
        check({tag, "_vld"},   32'(res_valid), 32'd1);
        check({tag, "_data"},  32'(res_data),  32'(r.data));
        check({tag, "_carry"}, 32'(res_carry), 32'(r.carry));
        check({tag, "_gt"},    32'(res_gt),    32'(r.gt));
        check({tag, "_eq"},    32'(res_eq),    32'(r.eq));
        check({tag, "_lt"},    32'(res_lt),    32'(r.lt));
    endtask

    task automatic chk_state(input string tag, input logic [3:0] c,
                             input logic f, input logic e);
        check({tag, "_count"}, 32'(count), 32'(c));
        check({tag, "_full"},  32'(full),  32'(f));
        check({tag, "_empty"}, 32'(empty), 32'(e));
    endtask

    task automatic fill8(input logic [7:0] base);
        res_ready = 1'b0;
        for (int i = 0; i < 8; i++) cyc(1'b1, mk(base + 8'(i)));
        cyc(1'b0, junk);
    endtask

    initial begin
        alu_result_t add35;
        int unsigned out_idx;
        int unsigned in_idx;

        junk = mk(8'hEE);
        pend = junk;

        // Reset state
        tick();
        tick();
        chk_state("rst", 4'd0, 1'b0, 1'b1);
        check("rst_vld", 32'(res_valid), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        arst = 1'b0;
        tick();

        // Single push: 3+5 on every lane = 8, no carry, a<b on every lane
        add35 = '{data: 16'h8888, carry: 4'h0, gt: 4'h0, eq: 4'h0, lt: 4'hF};
        cyc(1'b1, add35);
        check("single_lat_vld", 32'(res_valid), 32'd0);
        cyc(1'b0, junk);
        chk_head("single", add35);
        chk_state("single", 4'd1, 1'b0, 1'b0);
        res_ready = 1'b1;
        cyc(1'b0, junk);
        res_ready = 1'b0;
        chk_state("single_pop", 4'd0, 1'b0, 1'b1);

        // Fill to full, ninth result dropped, drain in order
        fill8(8'h10);
        chk_state("fill", 4'd8, 1'b1, 1'b0);
        check("fill_ovf0", 32'(overflow), 32'd0);
        cyc(1'b1, mk(8'h18));
        cyc(1'b0, junk);
        check("fill_ovf1", 32'(overflow), 32'd1);
        check("fill_cnt9", 32'(count), 32'd8);
        res_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk_head($sformatf("drain%0d", i), mk(8'h10 + 8'(i)));
            cyc(1'b0, junk);
        end
        res_ready = 1'b0;
        chk_state("drained", 4'd0, 1'b0, 1'b1);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // clr_ovf with no drop
        clr_ovf = 1'b1;
        cyc(1'b0, junk);
        clr_ovf = 1'b0;
        check("clr_ovf", 32'(overflow), 32'd0);

        // Full with concurrent pop and push
        fill8(8'h20);
        cyc(1'b1, mk(8'h64));
        res_ready = 1'b1;
        cyc(1'b0, junk);
        res_ready = 1'b0;
        chk_state("fullpp", 4'd8, 1'b1, 1'b0);
        check("fullpp_ovf", 32'(overflow), 32'd0);
        res_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            chk_head($sformatf("fpp%0d", i), mk(8'h20 + 8'(i)));
            cyc(1'b0, junk);
        end
        chk_head("fpp_last", mk(8'h64));
        cyc(1'b0, junk);
        res_ready = 1'b0;
        chk_state("fpp_done", 4'd0, 1'b0, 1'b1);

        // Drop coincident with clr_ovf keeps overflow set; flush leaves it
        fill8(8'h30);
        cyc(1'b1, mk(8'h40));
        cyc(1'b0, junk);
        check("ovf_a", 32'(overflow), 32'd1);
        cyc(1'b1, mk(8'h41));
        clr_ovf = 1'b1;
        cyc(1'b0, junk);
        clr_ovf = 1'b0;
        check("ovf_coinc", 32'(overflow), 32'd1);
        flush = 1'b1;
        cyc(1'b0, junk);
        flush = 1'b0;
        chk_state("flush_full", 4'd0, 1'b0, 1'b1);
        check("flush_ovf", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        cyc(1'b0, junk);
        clr_ovf = 1'b0;
        check("ovf_clr2", 32'(overflow), 32'd0);

        // Wrap: 20 issues, bursty 50% ready, strict order, count <= 8
        out_idx = 0;
        in_idx = 0;
        for (int i = 0; i < 40; i++) begin
            res_ready = ((i % 4) < 2);
            if (res_valid && res_ready) begin
                chk_head($sformatf("wrap%0d", out_idx), mk(8'h80 + 8'(out_idx)));
                out_idx++;
            end
            if (i % 2 == 0) begin
                cyc(1'b1, mk(8'h80 + 8'(in_idx)));
                in_idx++;
            end else begin
                cyc(1'b0, junk);
            end
            check("wrap_cnt_le8", 32'(count <= 4'd8), 32'd1);
        end
        res_ready = 1'b1;
        for (int i = 0; i < 40 && out_idx < 20; i++) begin
            if (res_valid) begin
                chk_head($sformatf("wrap%0d", out_idx), mk(8'h80 + 8'(out_idx)));
                out_idx++;
            end
            cyc(1'b0, junk);
        end
        res_ready = 1'b0;
        check("wrap_all_out", 32'(out_idx), 32'd20);
        check("wrap_ovf", 32'(overflow), 32'd0);
        chk_state("wrap_end", 4'd0, 1'b0, 1'b1);

        // Flush with a result in flight
        cyc(1'b1, mk(8'h50));
        cyc(1'b1, mk(8'h51));
        cyc(1'b1, mk(8'h52));
        cyc(1'b1, mk(8'h53));
        check("fl_pre_cnt", 32'(count), 32'd3);
        flush = 1'b1;
        cyc(1'b0, junk);
        flush = 1'b0;
        chk_state("fl", 4'd0, 1'b0, 1'b1);
        cyc(1'b0, junk);
        check("fl_inflight", 32'(count), 32'd0);
        // Enable issued in the flush cycle is discarded too
        flush = 1'b1;
        cyc(1'b1, mk(8'h54));
        flush = 1'b0;
        cyc(1'b0, junk);
        check("fl_en_same", 32'(count), 32'd0);

        // Asynchronous reset mid-cycle with a result in flight
        cyc(1'b1, mk(8'h60));
        cyc(1'b1, mk(8'h61));
        cyc(1'b1, mk(8'h62));
        cyc(1'b1, mk(8'h63));
        check("ar_pre_cnt", 32'(count), 32'd3);
        #3;
        arst = 1'b1;
        #1;
        chk_state("ar", 4'd0, 1'b0, 1'b1);
        check("ar_vld", 32'(res_valid), 32'd0);
        enable = 1'b0;
        pend = junk;
        tick();
        arst = 1'b0;
        cyc(1'b0, junk);
        check("ar_inflight", 32'(count), 32'd0);
        cyc(1'b1, mk(8'h70));
        check("ar_first_lat", 32'(res_valid), 32'd0);
        cyc(1'b0, junk);
        chk_head("ar_first", mk(8'h70));
        check("ar_first_cnt", 32'(count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
